rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
Oldest-first issue selector for one reservation station feeding one functional unit.
- Tracks allocation order of RS entries in an age matrix.
- Each cycle, picks the oldest requesting (ready) entry and offers it to the FU with a valid/ready handshake.
- On acceptance, returns a one-hot clear pulse so the RS frees the entry.
- Sits between the RS entry array (req vector) and the FU issue port.

Parameters:
RS_ENTRIES, 8, number of RS entries (power of 2, ≥2)
IDX_W, $clog2(RS_ENTRIES), entry index width
STALL_W, 16, width of the saturating stall counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  reset, synchronous, active-high
alloc_valid  in  1  RS allocates entry alloc_idx this cycle
alloc_idx  in  IDX_W  entry being allocated; becomes youngest
req  in  RS_ENTRIES  per-entry ready-to-issue (valid and operands ready)
flush  in  1  pipeline flush; abandon any offer, clear age state
fu_ready  in  1  FU accepts the offered entry this cycle
issue_valid  out  1  offer valid (registered)
issue_idx  out  IDX_W  offered entry index (registered)
issue_grant  out  RS_ENTRIES  one-hot of issue_idx, 0 when !issue_valid
entry_clear  out  RS_ENTRIES  one-hot pulse, 1 cycle, on handshake (combinational: issue_grant & {fu_ready})
stall_count  out  STALL_W  cycles with issue_valid && !fu_ready, saturating

Behaviour:
- Reset (rst=1 at posedge): issue_valid=0, issue_idx=0, issue_grant=0, stall_count=0, age matrix all 0, FSM=IDLE. Reset overrides every other input, including a mid-offer state.
- Age matrix age[i][j]=1 means entry i is older than j. On alloc_valid for index k: age[k][*]=0 and age[j][k]=1 for all j≠k.
- Selection (combinational):
  - Eligible set: E = req & ~handshake_mask, where handshake_mask = entry_clear of the current cycle.
  - Winner: i in E such that no j in E has age[j][i]=1.
  - Tie with all-zero age rows (post-reset or post-flush): lowest index wins.
- FSM states:
  - IDLE: issue_valid=0. If E≠0, register winner and go to OFFER.
  - OFFER: issue_valid=1, issue_idx/issue_grant held stable. No re-arbitration while fu_ready=0, even if an older entry becomes ready.
    - Handshake (fu_ready=1): entry_clear pulses. If E≠0 (the issued entry is excluded), load the new winner and stay in OFFER for back-to-back issue. Otherwise go to IDLE.
    - No handshake (fu_ready=0): stall_count += 1, saturating at all-ones.
- Latency: req rising in cycle N gives issue_valid in cycle N+1. Sustained throughput is 1 issue/cycle when fu_ready=1.
- Flush: at the posedge go to IDLE with issue_valid=0 and the age matrix zeroed.
  - entry_clear is forced 0 in a flush cycle.
  - Flush beats a simultaneous alloc_valid; the alloc is ignored.
  - stall_count is not cleared by flush.
- Alloc and age update happen at the same edge as selection. The selection in that cycle uses the pre-update matrix.
- Illegal input, covered by an assertion only: alloc_idx equal to the offered idx while issue_valid=1, or equal to an idx cleared in the same cycle.
- Wrap: a reused index is always youngest after its new alloc, whatever its previous age.

Test Plan:
- Reset, alloc 3,1,5 on consecutive cycles, then req={3,1,5} with fu_ready=1 → issue_idx 3,1,5 in consecutive cycles; entry_clear 0x08, 0x02, 0x20; issue_valid drops the cycle after req clears.
- Offer idx 5 with fu_ready=0 for 4 cycles; raise req[3] (older) in cycle 2 → issue_idx stays 5; stall_count=4; after fu_ready=1 the next offer is 3.
- Offering idx 1 with fu_ready=0, assert flush together with alloc_valid idx 2 → next cycle issue_valid=0, entry_clear never pulses, age all 0; a later req=0x06 issues 1 (lowest index tie-break).
- rst asserted mid-offer with stall_count=7 → next cycle all outputs 0, and re-arbitration only begins after rst deasserts.
- Alloc 0..7, handshake 0, re-alloc 0, req=0x81 → issues 7 first, then 0.
- Hold an offer with fu_ready=0 for 65540 cycles → stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue selector for one reservation station feeding one FU.
// An age matrix records allocation order. Each cycle the oldest ready
// entry is offered to the FU through a registered valid/ready handshake.
// A one-hot clear pulse is returned to the RS when the FU takes an entry.

// Checks for illegal stimulus and for consistency of the offer outputs.
module rs_issue_scheduler_chk #(
    parameter int RS_ENTRIES = 8,
    parameter int IDX_W      = $clog2(RS_ENTRIES)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  alloc_valid,
    input logic [IDX_W-1:0]      alloc_idx,
    input logic                  flush,
    input logic                  issue_valid,
    input logic [IDX_W-1:0]      issue_idx,
    input logic [RS_ENTRIES-1:0] issue_grant
);

    // The offered entry (which is also the only one that can be cleared) must not be re-allocated.
    a_alloc_not_offered: assert property (@(posedge clk) disable iff (rst)
        (alloc_valid && !flush && issue_valid) |-> (alloc_idx != issue_idx));

    // The grant is the one-hot of the offered index while an offer is up.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        issue_valid |-> (issue_grant == ({{(RS_ENTRIES-1){1'b0}}, 1'b1} << issue_idx)));

    // The grant is quiet when nothing is offered.
    a_grant_idle: assert property (@(posedge clk) disable iff (rst)
        !issue_valid |-> (issue_grant == {RS_ENTRIES{1'b0}}));

endmodule

module rs_issue_scheduler #(
    parameter int RS_ENTRIES = 8,
    parameter int IDX_W      = $clog2(RS_ENTRIES),
    parameter int STALL_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [IDX_W-1:0]      alloc_idx,
    input  logic [RS_ENTRIES-1:0] req,
    input  logic                  flush,
    input  logic                  fu_ready,
    output logic                  issue_valid,
    output logic [IDX_W-1:0]      issue_idx,
    output logic [RS_ENTRIES-1:0] issue_grant,
    output logic [RS_ENTRIES-1:0] entry_clear,
    output logic [STALL_W-1:0]    stall_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // age_r[i][j] = 1 means entry i was allocated before entry j.
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_r;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [IDX_W-1:0]        issue_idx_r;
    logic [IDX_W-1:0]        idx_nx_s;
    logic [RS_ENTRIES-1:0]   issue_grant_r;
    logic [STALL_W-1:0]      stall_r;
    logic [STALL_W-1:0]      stall_nx_s;

    logic [RS_ENTRIES-1:0]   clear_s;
    logic [RS_ENTRIES-1:0]   elig_s;
    logic [RS_ENTRIES-1:0]   win_vec_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_any_s;

    function automatic logic [RS_ENTRIES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [RS_ENTRIES-1:0] v;
        v      = {RS_ENTRIES{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Lowest set bit wins; only matters when several entries have no older rival.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [RS_ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // The clear pulse follows the handshake; a flush abandons the offer without freeing it.
    assign clear_s     = issue_grant_r & {RS_ENTRIES{fu_ready & ~flush}};
    assign elig_s      = req & ~clear_s;
    assign entry_clear = clear_s;
    assign issue_valid = (state_r == ST_OFFER);
    assign issue_idx   = issue_idx_r;
    assign issue_grant = issue_grant_r;
    assign stall_count = stall_r;

    // Oldest eligible entry: one that no other eligible entry is older than.
    always_comb begin : sel_comb
        logic blocked_v;
        win_vec_s = {RS_ENTRIES{1'b0}};
        blocked_v = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            blocked_v = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                blocked_v = blocked_v | (elig_s[j] & age_r[j][i]);
            end
            win_vec_s[i] = elig_s[i] & ~blocked_v;
        end
        win_any_s = |elig_s;
        win_idx_s = lowest_idx(win_vec_s);
    end

    // Next-state, next offer and stall counter logic for the offer FSM.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = issue_idx_r;
        stall_nx_s = stall_r;
        if (issue_valid && !fu_ready && (stall_r != {STALL_W{1'b1}})) begin
            stall_nx_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_nx_s = stall_r;
        end
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_any_s) begin
                        state_nx_s = ST_OFFER;
                        idx_nx_s   = win_idx_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    // The offer is frozen until the FU takes it, even if an older entry wakes up.
                    if (fu_ready) begin
                        if (win_any_s) begin
                            state_nx_s = ST_OFFER;
                            idx_nx_s   = win_idx_s;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_OFFER;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, registered offer outputs and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            issue_idx_r   <= {IDX_W{1'b0}};
            issue_grant_r <= {RS_ENTRIES{1'b0}};
            stall_r       <= {STALL_W{1'b0}};
        end else begin
            state_r       <= state_nx_s;
            issue_idx_r   <= idx_nx_s;
            issue_grant_r <= (state_nx_s == ST_OFFER) ? idx_to_onehot(idx_nx_s)
                                                      : {RS_ENTRIES{1'b0}};
            stall_r       <= stall_nx_s;
        end
    end

    // Age matrix: a new allocation becomes younger than every other entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_r <= {(RS_ENTRIES*RS_ENTRIES){1'b0}};
        end else if (flush) begin
            age_r <= {(RS_ENTRIES*RS_ENTRIES){1'b0}};
        end else if (alloc_valid) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (IDX_W'(j) == alloc_idx) begin
                    age_r[j] <= {RS_ENTRIES{1'b0}};
                end else begin
                    age_r[j][alloc_idx] <= 1'b1;
                end
            end
        end else begin
            age_r <= age_r;
        end
    end

    rs_issue_scheduler_chk #(
        .RS_ENTRIES (RS_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_grant (issue_grant)
    );

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: a per-cycle vector table plus a
// hand-written stall-counter saturation sequence.
module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [2:0]  alloc_idx;
    logic [7:0]  req;
    logic        flush;
    logic        fu_ready;
    logic        issue_valid;
    logic [2:0]  issue_idx;
    logic [7:0]  issue_grant;
    logic [7:0]  entry_clear;
    logic [15:0] stall_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        av;
        logic [2:0]  ai;
        logic [7:0]  rq;
        logic        fl;
        logic        fr;
        logic        ev;
        logic [2:0]  ei;
        logic        ci;
        logic [7:0]  ec;
        logic [15:0] es;
    } vec_t;

    vec_t vecs[$];

    rs_issue_scheduler #(
        .RS_ENTRIES (8),
        .IDX_W      (3),
        .STALL_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .req         (req),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_grant (issue_grant),
        .entry_clear (entry_clear),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
        end
    endtask

    // Row fields: rst, alloc_valid, alloc_idx, req, flush, fu_ready,
    // then expected issue_valid, issue_idx, check-idx flag, entry_clear, stall_count.
    // Expected outputs are those visible during the row's cycle, before its closing edge.
    task automatic add(input logic r_, input logic a_, input logic [2:0] ai_, input logic [7:0] rq_,
                       input logic f_, input logic fr_, input logic e_, input logic [2:0] ei_,
                       input logic c_, input logic [7:0] ec_, input logic [15:0] es_);
        vec_t v;
        v.rst = r_; v.av = a_; v.ai = ai_; v.rq = rq_; v.fl = f_; v.fr = fr_;
        v.ev = e_; v.ei = ei_; v.ci = c_ | e_; v.ec = ec_; v.es = es_;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] g;
        vec_t v;

        rst = 1'b1; alloc_valid = 1'b0; alloc_idx = 3'd0; req = 8'h00; flush = 1'b0; fu_ready = 1'b0;

        // Alloc 3,1,5 then back-to-back issue in age order.
        add(0,1,3,8'h00,0,1, 0,0,1,8'h00,0);
        add(0,1,1,8'h00,0,1, 0,0,0,8'h00,0);
        add(0,1,5,8'h00,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h2A,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h2A,0,1, 1,3,1,8'h08,0);
        add(0,0,0,8'h22,0,1, 1,1,1,8'h02,0);
        add(0,0,0,8'h20,0,1, 1,5,1,8'h20,0);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,0);
        // Offer 5 held for 4 stall cycles while older entry 3 wakes up.
        add(0,0,0,8'h20,0,0, 0,0,0,8'h00,0);
        add(0,0,0,8'h20,0,0, 1,5,1,8'h00,0);
        add(0,0,0,8'h28,0,0, 1,5,1,8'h00,1);
        add(0,0,0,8'h28,0,0, 1,5,1,8'h00,2);
        add(0,0,0,8'h28,0,0, 1,5,1,8'h00,3);
        add(0,0,0,8'h28,0,1, 1,5,1,8'h20,4);
        add(0,0,0,8'h08,0,1, 1,3,1,8'h08,4);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,4);
        // Flush with simultaneous alloc 2 while offering 1 stalled.
        add(0,0,0,8'h02,0,0, 0,0,0,8'h00,4);
        add(0,0,0,8'h02,0,0, 1,1,1,8'h00,4);
        add(0,1,2,8'h02,1,0, 1,1,1,8'h00,5);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,6);
        add(0,0,0,8'h06,0,1, 0,0,0,8'h00,6);
        add(0,0,0,8'h06,0,1, 1,1,1,8'h02,6);
        add(0,0,0,8'h04,0,1, 1,2,1,8'h04,6);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,6);
        // Alloc during flush was ignored: 2 and 3 still tie, lowest index first.
        add(0,0,0,8'h0C,0,1, 0,0,0,8'h00,6);
        add(0,0,0,8'h0C,0,1, 1,2,1,8'h04,6);
        add(0,0,0,8'h08,0,1, 1,3,1,8'h08,6);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,6);
        // Flush with fu_ready=1 suppresses the clear pulse.
        add(0,0,0,8'h01,0,1, 0,0,0,8'h00,6);
        add(0,0,0,8'h01,1,1, 1,0,1,8'h00,6);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,6);
        // Reset mid-offer with stall_count=7.
        add(0,0,0,8'h10,0,0, 0,0,0,8'h00,6);
        add(0,0,0,8'h10,0,0, 1,4,1,8'h00,6);
        add(1,0,0,8'h10,0,0, 1,4,1,8'h00,7);
        add(1,0,0,8'h10,0,0, 0,0,1,8'h00,0);
        add(0,0,0,8'h10,0,0, 0,0,1,8'h00,0);
        add(0,0,0,8'h10,0,1, 1,4,1,8'h10,0);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,0);
        // Alloc 0..7, issue 0, re-alloc 0: 0 is now youngest.
        for (int k = 0; k < 8; k++) add(0,1,3'(k),8'h00,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h01,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h01,0,1, 1,0,1,8'h01,0);
        add(0,1,0,8'h00,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h81,0,1, 0,0,0,8'h00,0);
        add(0,0,0,8'h81,0,1, 1,7,1,8'h80,0);
        add(0,0,0,8'h01,0,1, 1,0,1,8'h01,0);
        add(0,0,0,8'h00,0,1, 0,0,0,8'h00,0);

        repeat (2) @(posedge clk);

        foreach (vecs[r]) begin
            v = vecs[r];
            @(negedge clk);
            rst = v.rst; alloc_valid = v.av; alloc_idx = v.ai; req = v.rq;
            flush = v.fl; fu_ready = v.fr;
            #1;
            g = v.ev ? (8'h01 << v.ei) : 8'h00;
            chk("issue_valid", r, {31'd0, issue_valid}, {31'd0, v.ev});
            if (v.ci) chk("issue_idx", r, {29'd0, issue_idx}, {29'd0, v.ei});
            chk("issue_grant", r, {24'd0, issue_grant}, {24'd0, g});
            chk("entry_clear", r, {24'd0, entry_clear}, {24'd0, v.ec});
            chk("stall_count", r, {16'd0, stall_count}, {16'd0, v.es});
        end

        // Stall counter saturation on a long-held offer.
        @(negedge clk);
        rst = 1'b0; alloc_valid = 1'b0; flush = 1'b0; req = 8'h02; fu_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("sat_offer_valid", 0, {31'd0, issue_valid}, 32'd1);
        chk("sat_offer_idx", 0, {29'd0, issue_idx}, 32'd1);
        chk("sat_start", 0, {16'd0, stall_count}, 32'd0);
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_pre", 1, {16'd0, stall_count}, 32'h0000FFFE);
        repeat (6) @(negedge clk);
        #1;
        chk("sat_full", 2, {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_hold_idx", 2, {29'd0, issue_idx}, 32'd1);
        fu_ready = 1'b1;
        #1;
        chk("sat_clear", 3, {24'd0, entry_clear}, 32'h00000002);
        @(negedge clk);
        req = 8'h00;
        #1;
        chk("sat_idle_valid", 4, {31'd0, issue_valid}, 32'd0);
        chk("sat_keep", 4, {16'd0, stall_count}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
